uart_rx_cmd_parser: RTL and testbench
=====================================

# uart_rx_cmd_parser

Command-frame decoder directly downstream of the UART receiver. Consumes received bytes and their error flags, recognises four command frames (register write, register read, ALU operation with operands, ALU operation without operands) and issues one-cycle register-file and ALU strobes. Aborts a partial frame on a receive error or an inter-byte timeout.

## Interface
- DATA_WIDTH, 8: byte width of received data and register-file data.
- ADDR_WIDTH, 4: register-file address width; address bytes are truncated to the low ADDR_WIDTH bits.
- TIMEOUT_CYCLES, 4096: idle cycles allowed between bytes of one frame; must be ≥2 and fit in 16 bits.

- CLK  in  1  system clock; all logic rises on this edge.
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte, valid when RX_D_VLD=1.
- RX_D_VLD  in  1  one cycle high per received byte.
- RX_PAR_ERR  in  1  receiver parity error flag.
- RX_STP_ERR  in  1  receiver framing (stop-bit) error flag.
- RF_WrEn  out  1  one-cycle register-file write strobe.
- RF_RdEn  out  1  one-cycle register-file read strobe.
- RF_Address  out  ADDR_WIDTH  register-file address; holds between strobes.
- RF_WrData  out  DATA_WIDTH  register-file write data; holds between strobes.
- ALU_EN  out  1  one-cycle ALU enable strobe.
- ALU_FUN  out  4  ALU function code (low 4 bits of FUN byte); holds between strobes.
- FRAME_BUSY  out  1  high while a frame is partially received (state ≠ IDLE).
- CMD_ERR  out  1  one-cycle pulse on unknown opcode, error abort or timeout.

## Operation
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, NOP_FUN. Reset → IDLE.
- IDLE, byte accepted: 0xAA → WR_ADDR; 0xBB → RD_ADDR; 0xCC → ALU_A; 0xDD → NOP_FUN; any other value → CMD_ERR pulse, stay IDLE.
- WR_ADDR: latch address → WR_DATA. WR_DATA: RF_WrEn with latched address and the byte → IDLE.
- RD_ADDR: RF_RdEn with RF_Address = byte → IDLE.
- ALU_A: RF_WrEn, address 0, data = byte → ALU_B. ALU_B: RF_WrEn, address 1, data = byte → ALU_FUN.
- ALU_FUN / NOP_FUN: ALU_EN with ALU_FUN = byte[3:0] → IDLE.
- Error abort: RX_PAR_ERR or RX_STP_ERR high on any cycle in a non-IDLE state → IDLE, one CMD_ERR pulse, no strobe. In IDLE: flags high together with RX_D_VLD discard that byte with CMD_ERR; otherwise ignored.
- Timeout: 16-bit counter cleared on every accepted byte and in IDLE, increments each cycle in non-IDLE. Reaching TIMEOUT_CYCLES−1 → IDLE, CMD_ERR pulse; counter saturates, never wraps.
- Priority in one cycle: reset > error abort > accepted byte > timeout.
- Strobes are mutually exclusive; at most one of RF_WrEn, RF_RdEn, ALU_EN, CMD_ERR high per cycle.

## Timing
- All outputs registered. Reset value of every output: 0.
- Strobe/CMD_ERR latency: asserted in the cycle after the RX_D_VLD cycle of the completing byte (or error/timeout detection), high exactly one cycle.
- RF_Address, RF_WrData, ALU_FUN update in the same cycle as their strobe and hold afterwards.
- FRAME_BUSY rises the cycle after a valid opcode, falls together with the completing strobe or CMD_ERR.
- Back-to-back bytes on consecutive cycles are accepted; no backpressure.
- Reset mid-frame: immediate return to IDLE, partial frame discarded, no strobe after release.

## Test plan
- Bytes 0xAA, 0x05, 0x3C → one RF_WrEn cycle with RF_Address=5, RF_WrData=0x3C; FRAME_BUSY high from cycle after 0xAA to that strobe.
- Bytes 0xBB, 0x17 → RF_RdEn one cycle, RF_Address=7 (truncated); no RF_WrEn.
- Bytes 0xCC, 0x10, 0x20, 0x03 → RF_WrEn (addr 0, 0x10), RF_WrEn (addr 1, 0x20), ALU_EN with ALU_FUN=3; then 0xDD, 0x0A → ALU_EN, ALU_FUN=0xA.
- Byte 0x55 in IDLE → CMD_ERR one cycle, FRAME_BUSY stays 0; then 0xBB, 0x02 decodes normally.
- 0xAA, 0x01 then RX_STP_ERR pulse → CMD_ERR, IDLE, no RF_WrEn; 0xAA, 0x01 then no byte for TIMEOUT_CYCLES → CMD_ERR once, IDLE.
- RST asserted after 0xCC, 0x10 → all outputs 0 immediately; after release, 0x20 alone produces CMD_ERR (unknown opcode), not RF_WrEn.

Source files
------------

// File: rtl/uart_rx_cmd_parser.sv
// rtl/uart_rx_cmd_parser.sv - command-frame decoder behind the UART receiver
module uart_rx_cmd_parser #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_PAR_ERR,
  input  logic                  RX_STP_ERR,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  FRAME_BUSY,
  output logic                  CMD_ERR
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FN, NOP_FN
  } state_t;

  localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_NOP = DATA_WIDTH'(8'hDD);
  localparam logic [15:0]           TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state_q;
  logic [15:0]             cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_lat_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              fun_q;
  logic                    wr_en_q;
  logic                    rd_en_q;
  logic                    alu_en_q;
  logic                    busy_q;
  logic                    err_q;

  logic rx_err;
  logic byte_ok;

  assign rx_err  = RX_PAR_ERR | RX_STP_ERR;
  assign byte_ok = RX_D_VLD & ~rx_err;

  // Frame FSM; every output is a register written alongside the state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_lat_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fun_q      <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      alu_en_q <= 1'b0;
      err_q    <= 1'b0;
      if (state_q == IDLE) begin
        cnt_q <= '0;
        if (RX_D_VLD && rx_err) begin
          err_q <= 1'b1;
        end else if (byte_ok) begin
          busy_q <= 1'b1;
          case (RX_P_DATA)
            OP_WR:   state_q <= WR_ADDR;
            OP_RD:   state_q <= RD_ADDR;
            OP_ALU:  state_q <= ALU_A;
            OP_NOP:  state_q <= NOP_FN;
            default: begin
              busy_q <= 1'b0;
              err_q  <= 1'b1;
            end
          endcase
        end
      end else if (rx_err) begin
        // Receive error aborts the partial frame without any strobe.
        state_q <= IDLE;
        busy_q  <= 1'b0;
        err_q   <= 1'b1;
        cnt_q   <= '0;
      end else if (byte_ok) begin
        cnt_q <= '0;
        case (state_q)
          WR_ADDR: begin
            addr_lat_q <= RX_P_DATA[ADDR_WIDTH-1:0];
            state_q    <= WR_DATA;
          end
          WR_DATA: begin
            addr_q  <= addr_lat_q;
            wdata_q <= RX_P_DATA;
            wr_en_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          RD_ADDR: begin
            addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
            rd_en_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          ALU_A: begin
            addr_q  <= '0;
            wdata_q <= RX_P_DATA;
            wr_en_q <= 1'b1;
            state_q <= ALU_B;
          end
          ALU_B: begin
            addr_q  <= ADDR_WIDTH'(1);
            wdata_q <= RX_P_DATA;
            wr_en_q <= 1'b1;
            state_q <= ALU_FN;
          end
          default: begin
            // ALU_FN and NOP_FN both finish with the function byte.
            fun_q    <= RX_P_DATA[3:0];
            alu_en_q <= 1'b1;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end
        endcase
      end else if (cnt_q == TO_LAST) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        err_q   <= 1'b1;
        cnt_q   <= '0;
      end else if (cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign RF_WrEn    = wr_en_q;
  assign RF_RdEn    = rd_en_q;
  assign RF_Address = addr_q;
  assign RF_WrData  = wdata_q;
  assign ALU_EN     = alu_en_q;
  assign ALU_FUN    = fun_q;
  assign FRAME_BUSY = busy_q;
  assign CMD_ERR    = err_q;

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// tb/tb_uart_rx_cmd_parser.sv - scoreboard bench for uart_rx_cmd_parser
module tb_uart_rx_cmd_parser;

  localparam int TO   = 20;
  localparam int MAXC = 8192;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic       RX_PAR_ERR = 1'b0;
  logic       RX_STP_ERR = 1'b0;
  logic       RF_WrEn, RF_RdEn, ALU_EN, FRAME_BUSY, CMD_ERR;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData;
  logic [3:0] ALU_FUN;

  uart_rx_cmd_parser #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RX_PAR_ERR(RX_PAR_ERR), .RX_STP_ERR(RX_STP_ERR), .RF_WrEn(RF_WrEn),
    .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .FRAME_BUSY(FRAME_BUSY), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // kind: 0 write, 1 read, 2 alu, 3 cmd error
  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] fun;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] frame[$];
  int         last_t = 0;
  logic [3:0] h_addr = '0;
  logic [7:0] h_data = '0;
  logic [3:0] h_fun  = '0;
  bit         bz_v[MAXC];
  bit         bz[MAXC];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic push_ev(input int t, input int kind);
    ev_t e;
    e.cyc = t; e.kind = kind; e.addr = h_addr; e.data = h_data; e.fun = h_fun;
    exp_q.push_back(e);
  endtask

  // Reference: collect bytes of the current frame, decide on frame length per opcode.
  task automatic model(input int t, input logic v, input logic [7:0] d,
                       input logic pe, input logic se);
    logic errf;
    errf = pe | se;
    if (frame.size() > 0 && errf) begin
      push_ev(t + 1, 3);
      frame.delete();
    end else if (frame.size() == 0 && v && errf) begin
      push_ev(t + 1, 3);
    end else if (v && !errf) begin
      last_t = t;
      frame.push_back(d);
      case (frame[0])
        8'hAA: if (frame.size() == 3) begin
          h_addr = frame[1][3:0]; h_data = frame[2];
          push_ev(t + 1, 0); frame.delete();
        end
        8'hBB: if (frame.size() == 2) begin
          h_addr = frame[1][3:0];
          push_ev(t + 1, 1); frame.delete();
        end
        8'hCC: begin
          if (frame.size() == 2) begin
            h_addr = 4'd0; h_data = frame[1]; push_ev(t + 1, 0);
          end else if (frame.size() == 3) begin
            h_addr = 4'd1; h_data = frame[2]; push_ev(t + 1, 0);
          end else if (frame.size() == 4) begin
            h_fun = frame[3][3:0]; push_ev(t + 1, 2); frame.delete();
          end
        end
        8'hDD: if (frame.size() == 2) begin
          h_fun = frame[1][3:0];
          push_ev(t + 1, 2); frame.delete();
        end
        default: begin
          push_ev(t + 1, 3); frame.delete();
        end
      endcase
    end else if (frame.size() > 0 && (t - last_t) == TO) begin
      push_ev(t + 1, 3);
      frame.delete();
    end
    if (t + 1 < MAXC) begin
      bz_v[t + 1] = 1'b1;
      bz[t + 1]   = (frame.size() > 0);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic pe, input logic se);
    @(posedge CLK); #1;
    RX_D_VLD = v; RX_P_DATA = d; RX_PAR_ERR = pe; RX_STP_ERR = se;
    model(cyc, v, d, pe, se);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, 1'b0);
  endtask

  // Monitor: every strobe must match the head of the scoreboard in cycle and content.
  always @(negedge CLK) begin : mon
    int   ns;
    int   kind;
    ev_t  e;
    if (RST) begin
      ns = int'(RF_WrEn) + int'(RF_RdEn) + int'(ALU_EN) + int'(CMD_ERR);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        fail_now("missing_strobe");
        void'(exp_q.pop_front());
      end
      if (ns > 0) begin
        chk("strobe_onehot", ns, 1);
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          fail_now("unexpected_strobe");
        end else begin
          e = exp_q.pop_front();
          kind = RF_WrEn ? 0 : RF_RdEn ? 1 : ALU_EN ? 2 : 3;
          chk("strobe_kind", kind, e.kind);
          chk("rf_address", RF_Address, e.addr);
          chk("rf_wrdata", RF_WrData, e.data);
          chk("alu_fun", ALU_FUN, e.fun);
        end
      end
      if (cyc < MAXC && bz_v[cyc]) chk("frame_busy", FRAME_BUSY, bz[cyc]);
    end
  end

  initial begin
    int r;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_wren", RF_WrEn, 0);
    chk("reset_busy", FRAME_BUSY, 0);
    chk("reset_outs", {RF_RdEn, ALU_EN, CMD_ERR, RF_Address, RF_WrData, ALU_FUN}, 0);
    RST = 1'b1;
    idle(2);

    send(8'hAA); send(8'h05); send(8'h3C); idle(2);
    send(8'hBB); send(8'h17); idle(1);
    send(8'hCC); send(8'h10); send(8'h20); send(8'h03);
    send(8'hDD); send(8'h0A); idle(2);
    send(8'h55); send(8'hBB); send(8'h02); idle(2);
    send(8'hAA); send(8'h01); step(1'b0, 8'h00, 1'b0, 1'b1); idle(2);
    send(8'hAA); send(8'h01); idle(TO + 3);
    send(8'hAA); send(8'h02); idle(TO - 1); send(8'h77); idle(2);
    step(1'b1, 8'hAA, 1'b1, 1'b0); step(1'b0, 8'h00, 1'b1, 1'b1); idle(2);

    // Reset in the middle of an ALU frame.
    send(8'hCC); send(8'h10); idle(1);
    @(posedge CLK); #1;
    RST = 1'b0; RX_D_VLD = 1'b0;
    frame.delete(); h_addr = '0; h_data = '0; h_fun = '0;
    #1;
    chk("rst_mid_busy", FRAME_BUSY, 0);
    chk("rst_mid_outs", {RF_WrEn, RF_RdEn, ALU_EN, CMD_ERR, RF_Address, RF_WrData, ALU_FUN}, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    bz_v[cyc] = 1'b1; bz[cyc] = 1'b0;
    send(8'h20); idle(3);

    while (cyc < 3500) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        r = $urandom_range(1, 3);
        step(1'($urandom_range(0, 1)), 8'($urandom), r[0], r[1]);
      end else if (r < 8) begin
        idle($urandom_range(TO - 2, TO + 1));
      end else if (r < 40) begin
        idle(1);
      end else if (r < 70) begin
        r = $urandom_range(0, 3);
        send(r == 0 ? 8'hAA : r == 1 ? 8'hBB : r == 2 ? 8'hCC : 8'hDD);
      end else begin
        send(8'($urandom));
      end
    end
    idle(TO + 5);
    @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
